// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: tick, serial line and received-word signals of uart_rx_frame
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
    logic                 s_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 frame_error;
    logic                 parity_error;
    logic                 rx_break;
    modport master (
        output s_tick, rx,
        input  rx_data, rx_done, frame_error, parity_error, rx_break
    );
    modport slave (
        input  s_tick, rx,
        output rx_data, rx_done, frame_error, parity_error, rx_break
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with configurable width, parity and stop bits.
// Defining UART_RX_BREAK_DETECT_EN turns an all-zero frame into an rx_break pulse.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    uart_rx_frame_if.slave   bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_BREAK_DETECT_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif
    state_t               state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 zero_q, zero_d;
    logic                 pacc_q, pacc_d;
    logic                 facc_q, facc_d;
    logic                 done_q, done_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 brk_q, brk_d;
    logic                 rx, tick, mid;
    assign rx   = bus.rx;
    assign tick = bus.s_tick;
    assign mid  = (tcnt_q == FULL_M1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            pacc_q  <= 1'b0;
            facc_q  <= 1'b0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            pacc_q  <= pacc_d;
            facc_q  <= facc_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            brk_q   <= brk_d;
        end
    end
    // zero_q tracks whether every sample of the current frame has been 0 (break pattern)
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        zero_d  = zero_q;
        pacc_d  = pacc_q;
        facc_d  = facc_q;
        done_d  = 1'b0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        brk_d   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = START;
                        tcnt_d  = '0;
                    end
                end
                START: begin
                    if (tcnt_q == HALF_M1) begin
                        state_d = rx ? IDLE : DATA;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        zero_d  = 1'b1;
                        pacc_d  = 1'b0;
                        facc_d  = 1'b0;
                    end else
                        tcnt_d = tcnt_q + 1'b1;
                end
                DATA: begin
                    tcnt_d = mid ? '0 : tcnt_q + 1'b1;
                    if (mid) begin
                        sh_d   = {rx, sh_q[DATA_BITS-1:1]};
                        zero_d = zero_q & ~rx;
                        bcnt_d = (bcnt_q == 4'(DATA_BITS - 1)) ? '0 : bcnt_q + 1'b1;
                        if (bcnt_q == 4'(DATA_BITS - 1))
                            state_d = (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    tcnt_d = mid ? '0 : tcnt_q + 1'b1;
                    if (mid) begin
                        zero_d  = zero_q & ~rx;
                        pacc_d  = (^sh_q) ^ rx ^ (PARITY == 2);
                        bcnt_d  = '0;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    tcnt_d = mid ? '0 : tcnt_q + 1'b1;
                    if (mid) begin
                        facc_d = facc_q | ~rx;
                        zero_d = zero_q & ~rx;
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == 4'(STOP_BITS - 1)) begin
                            state_d = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                            if (zero_q && !rx) begin
                                brk_d   = 1'b1;
                                state_d = BRK_WAIT;
                            end else begin
                                done_d = 1'b1;
                                data_d = sh_q;
                                fe_d   = facc_q | ~rx;
                                pe_d   = pacc_q;
                            end
`else
                            done_d = 1'b1;
                            data_d = sh_q;
                            fe_d   = facc_q | ~rx;
                            pe_d   = pacc_q;
`endif
                        end
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BRK_WAIT: state_d = rx ? IDLE : BRK_WAIT;
`endif
                default: state_d = IDLE;
            endcase
        end
    end
    assign bus.rx_data      = data_q;
    assign bus.rx_done      = done_q;
    assign bus.frame_error  = fe_q;
    assign bus.parity_error = pe_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign bus.rx_break     = brk_q;
`else
    assign bus.rx_break     = 1'b0 & brk_q;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames into 8N1, 8E1 and 8N2 receivers, checked against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx_frame;
    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rst_edge = 1'b1;
    logic       rx_v [3];
    logic [3:0] pul [3];
    logic [7:0] dat [3];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         fall_cyc;
    exp_t       q [3][$];
    exp_t       ce;
    logic [7:0] held [3];
    int         dn [3];
    int         bk [3];
    int         last_cyc [3];
    logic [7:0] last_d [3];
    logic       last_fe [3];
    logic       last_pe [3];
    uart_rx_frame_if #(.DATA_BITS(8)) ia ();
    uart_rx_frame_if #(.DATA_BITS(8)) ib ();
    uart_rx_frame_if #(.DATA_BITS(8)) ic ();
    assign ia.s_tick = s_tick;
    assign ib.s_tick = s_tick;
    assign ic.s_tick = s_tick;
    assign ia.rx = rx_v[0];
    assign ib.rx = rx_v[1];
    assign ic.rx = rx_v[2];
    assign pul[0] = {ia.rx_done, ia.rx_break, ia.frame_error, ia.parity_error};
    assign pul[1] = {ib.rx_done, ib.rx_break, ib.frame_error, ib.parity_error};
    assign pul[2] = {ic.rx_done, ic.rx_break, ic.frame_error, ic.parity_error};
    assign dat[0] = ia.rx_data;
    assign dat[1] = ib.rx_data;
    assign dat[2] = ic.rx_data;
    uart_rx_frame #(.OVERSAMPLE(4)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    uart_rx_frame #(.OVERSAMPLE(4), .PARITY(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));
    uart_rx_frame #(.OVERSAMPLE(4), .STOP_BITS(2)) dut_c (.clk(clk), .reset(reset), .bus(ic));
    always #500 clk = ~clk;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= reset;
    end
    // tick on every posedge whose pre-edge count is a multiple of 26
    initial forever begin
        @(negedge clk);
        s_tick = (cyc % 26 == 0);
    end
    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h cyc %0d", nm, i, act, exp, cyc);
        end
    endtask
    // Frame model: bit list -> expected word/flags, due one clk after the last stop-sample tick.
    task automatic send(input int i, input logic [7:0] d, input bit hasp, input logic pb,
                        input int ns, input logic s0, input logic s1, input int lim);
        logic [15:0] b;
        int n, det;
        exp_t e;
        b = '1;
        n = 0;
        b[n] = 1'b0; n++;
        for (int k = 0; k < 8; k++) begin b[n] = d[k]; n++; end
        if (hasp) begin b[n] = pb; n++; end
        b[n] = s0; n++;
        if (ns == 2) begin b[n] = s1; n++; end
        @(negedge clk);
        fall_cyc = cyc;
        det = ((cyc + 25) / 26) * 26;
        if (lim == 0) begin
            e.cyc  = det + 26 * (2 + 4 * (n - 1)) + 1;
            e.data = d;
            e.fe   = (!s0) || (ns == 2 && !s1);
            e.pe   = hasp && ((^d) ^ pb);
            e.brk  = 1'b0;
            q[i].push_back(e);
        end
        for (int k = 0; k < ((lim != 0) ? lim : n); k++) begin
            rx_v[i] = b[k];
            repeat (104) @(negedge clk);
        end
        rx_v[i] = 1'b1;
    endtask
    initial forever begin
        @(negedge clk);
        if (rst_edge)
            for (int i = 0; i < 3; i++) begin
                q[i].delete();
                held[i] = '0;
            end
        for (int i = 0; i < 3; i++) begin
            if (q[i].size() > 0 && q[i][0].cyc == cyc) begin
                ce = q[i].pop_front();
                chk("event", i, 32'(pul[i]), 32'({!ce.brk, ce.brk, ce.fe, ce.pe}));
                if (!ce.brk) held[i] = ce.data;
            end else
                chk("pulses", i, 32'(pul[i]), 32'd0);
            chk("rx_data", i, 32'(dat[i]), 32'(held[i]));
            if (pul[i][3]) begin
                dn[i]++;
                last_cyc[i] = cyc;
                last_d[i]   = dat[i];
                last_fe[i]  = pul[i][1];
                last_pe[i]  = pul[i][0];
            end
            if (pul[i][2]) bk[i]++;
        end
    end
    initial begin
        int m, det, lat, d0;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            rx_v[i] = 1'b1;
            dn[i] = 0;
            bk[i] = 0;
            last_cyc[i] = 0;
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_data", i, 32'(dat[i]), 32'd0);
            chk("rst_pulse", i, 32'(pul[i]), 32'd0);
        end
        send(0, 8'h55, 0, 1'b0, 1, 1'b1, 1'b1, 0);
        lat = last_cyc[0] - fall_cyc;
        chk("lat_8n1", 0, 32'(lat >= 989 && lat <= 1014), 32'd1);
        send(0, 8'hA3, 0, 1'b0, 1, 1'b1, 1'b1, 0);
        chk("t1_count", 0, 32'(dn[0]), 32'd2);
        chk("t1_data", 0, 32'(last_d[0]), 32'hA3);
        chk("t1_fe", 0, 32'(last_fe[0]), 32'd0);
        send(1, 8'hC1, 1, 1'b1, 1, 1'b1, 1'b1, 0);
        lat = last_cyc[1] - fall_cyc;
        chk("lat_8e1", 1, 32'(lat >= 1093 && lat <= 1118), 32'd1);
        chk("t2_pe_ok", 1, 32'(last_pe[1]), 32'd0);
        send(1, 8'hC1, 1, 1'b0, 1, 1'b1, 1'b1, 0);
        chk("t2_pe_bad", 1, 32'(last_pe[1]), 32'd1);
        chk("t2_data", 1, 32'(last_d[1]), 32'hC1);
        chk("t2_count", 1, 32'(dn[1]), 32'd2);
        send(2, 8'h5A, 0, 1'b0, 2, 1'b1, 1'b1, 0);
        chk("t3_fe_ok", 2, 32'(last_fe[2]), 32'd0);
        send(2, 8'h3C, 0, 1'b0, 2, 1'b1, 1'b0, 0);
        chk("t3_fe_bad", 2, 32'(last_fe[2]), 32'd1);
        chk("t3_data", 2, 32'(last_d[2]), 32'h3C);
        repeat (300) @(negedge clk);
        chk("t3_count", 2, 32'(dn[2]), 32'd2);
        @(negedge clk);
        rx_v[0] = 1'b0;
        repeat (40) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (60) @(negedge clk);
        chk("t4_glitch", 0, 32'(dn[0]), 32'd2);
        send(0, 8'h7E, 0, 1'b0, 1, 1'b1, 1'b1, 0);
        chk("t4_data", 0, 32'(last_d[0]), 32'h7E);
        chk("t4_count", 0, 32'(dn[0]), 32'd3);
        @(negedge clk);
        m = cyc;
        det = ((m + 25) / 26) * 26;
        e.data = 8'h00;
        e.pe = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        e.cyc = det + 988 + 1; e.fe = 1'b0; e.brk = 1'b1;
        q[0].push_back(e);
`else
        e.cyc = det + 988 + 1; e.fe = 1'b1; e.brk = 1'b0;
        q[0].push_back(e);
        e.cyc = det + 988 + 26 + 988 + 1;
        q[0].push_back(e);
`endif
        rx_v[0] = 1'b0;
        repeat (2080) @(negedge clk);
        rx_v[0] = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
        chk("t5_break", 0, 32'(bk[0]), 32'd1);
        chk("t5_nodone", 0, 32'(dn[0]), 32'd3);
`else
        chk("t5_nobreak", 0, 32'(bk[0]), 32'd0);
        chk("t5_data", 0, 32'(last_d[0]), 32'h00);
        chk("t5_fe", 0, 32'(last_fe[0]), 32'd1);
`endif
        repeat (104) @(negedge clk);
        d0 = dn[0];
        send(0, 8'h12, 0, 1'b0, 1, 1'b1, 1'b1, 0);
        chk("t5_next", 0, 32'(last_d[0]), 32'h12);
        chk("t5_next_cnt", 0, 32'(dn[0] - d0), 32'd1);
        d0 = dn[0];
        send(0, 8'hF0, 0, 1'b0, 1, 1'b1, 1'b1, 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_rst_data", 0, 32'(dat[0]), 32'd0);
        repeat (100) @(negedge clk);
        send(0, 8'h0F, 0, 1'b0, 1, 1'b1, 1'b1, 0);
        chk("t6_count", 0, 32'(dn[0] - d0), 32'd1);
        chk("t6_data", 0, 32'(last_d[0]), 32'h0F);
        repeat (50) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("pending", i, 32'(q[i].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
